// File: rtl/range_reducer_pkg.sv
// Shared types for the range reducer and its hrange generator child.
package range_reducer_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [DATA_W:0]   ext_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALL,
        ST_WAIT,
        ST_DONE
    } state_e;

    // A range yields nothing when it cannot advance or is already exhausted.
    function automatic logic is_degenerate(data_t base, data_t limit, data_t step);
        return (step <= 0) || (base >= limit);
    endfunction

    function automatic ext_t sext(data_t v);
        return $signed({v[DATA_W-1], v});
    endfunction

endpackage

// File: rtl/range_reducer_if.sv
// Request/result bundle of the range reducer.
interface range_reducer_if;
    import range_reducer_pkg::*;

    logic  _start;
    data_t base;
    data_t limit;
    data_t step;
    data_t _0;
    data_t _1;
    logic  _ready;
    logic  _valid;

    modport master (output _start, base, limit, step, input _0, _1, _ready, _valid);
    modport slave  (input _start, base, limit, step, output _0, _1, _ready, _valid);

endinterface

// File: rtl/range_reducer_hrange.sv
// hrange generator: after _start yields base, base+step, ... below limit, one per cycle,
// then raises _ready with _valid low to mark the end of the run.
module range_reducer_hrange
    import range_reducer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  _start,
    input  data_t base,
    input  data_t limit,
    input  data_t step,
    output data_t _0,
    output logic  _valid,
    output logic  _ready
);

    ext_t  cur_q, cur_d;
    ext_t  lim_q, lim_d;
    ext_t  step_q, step_d;
    logic  run_q, run_d;
    data_t out_q, out_d;
    logic  valid_q, valid_d;
    logic  ready_q, ready_d;

    // Position is kept one bit wider so cur+step past the top of the range cannot wrap.
    always_comb begin
        cur_d   = cur_q;
        lim_d   = lim_q;
        step_d  = step_q;
        run_d   = run_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ready_d = ready_q;
        if (!run_q) begin
            ready_d = 1'b1;
            if (_start && !is_degenerate(base, limit, step)) begin
                out_d   = base;
                valid_d = 1'b1;
                cur_d   = sext(base) + sext(step);
                lim_d   = sext(limit);
                step_d  = sext(step);
                run_d   = 1'b1;
                ready_d = 1'b0;
            end
        end else if (cur_q < lim_q) begin
            out_d   = cur_q[DATA_W-1:0];
            valid_d = 1'b1;
            cur_d   = cur_q + step_q;
        end else begin
            run_d   = 1'b0;
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q   <= '0;
            lim_q   <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            cur_q   <= cur_d;
            lim_q   <= lim_d;
            step_q  <= step_d;
            run_q   <= run_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign _0     = out_q;
    assign _valid = valid_q;
    assign _ready = ready_q;

endmodule

// File: rtl/range_reducer.sv
// Range reducer: starts one hrange run and reports the wrapping sum and count of its values.
module range_reducer
    import range_reducer_pkg::*;
(
    input logic            _clock,
    input logic            _reset,
    range_reducer_if.slave io
);

    state_e state_q, state_d;
    data_t  base_q, base_d;
    data_t  limit_q, limit_d;
    data_t  step_q, step_d;
    data_t  sum_q, sum_d;
    data_t  cnt_q, cnt_d;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;
    logic   child_start_q, child_start_d;

    data_t  child_0;
    logic   child_valid;
    logic   child_ready;

    range_reducer_hrange u_child (
        .clk    (_clock),
        .rst    (_reset),
        ._start (child_start_q),
        .base   (base_q),
        .limit  (limit_q),
        .step   (step_q),
        ._0     (child_0),
        ._valid (child_valid),
        ._ready (child_ready)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        limit_d = limit_q;
        step_d  = step_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io._start) begin
                    base_d  = io.base;
                    limit_d = io.limit;
                    step_d  = io.step;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = is_degenerate(io.base, io.limit, io.step) ? ST_DONE : ST_CALL;
                end
            end
            ST_CALL: state_d = ST_WAIT;
            ST_WAIT: begin
                // A value arriving alongside child _ready is still accumulated.
                if (child_valid) begin
                    sum_d = sum_q + child_0;
                    cnt_d = cnt_q + DATA_W'(1);
                end
                if (child_ready) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d       = (state_d == ST_IDLE);
        valid_d       = (state_d == ST_DONE);
        child_start_d = (state_d == ST_CALL);
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            limit_q       <= '0;
            step_q        <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            ready_q       <= 1'b1;
            child_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            limit_q       <= limit_d;
            step_q        <= step_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            child_start_q <= child_start_d;
        end
    end

    assign io._0     = sum_q;
    assign io._1     = cnt_q;
    assign io._valid = valid_q;
    assign io._ready = ready_q;

endmodule

// File: tb/tb_range_reducer.sv
// Directed bench for range_reducer with hand-computed sums, counts and latencies.
module tb_range_reducer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   child_starts = 0;

    range_reducer_if bus ();

    range_reducer dut (
        ._clock (clk),
        ._reset (rst),
        .io     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.child_start_q) child_starts <= child_starts + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input int b, input int l, input int s,
                          input int exp_sum, input int exp_cnt, input int exp_lat);
        int lat;
        int starts0;
        @(negedge clk);
        check({tag, " ready_before"}, bus._ready, 1);
        starts0 = child_starts;
        bus._start = 1'b1;
        bus.base = b;
        bus.limit = l;
        bus.step = s;
        @(negedge clk);
        bus._start = 1'b0;
        lat = 1;
        while (!bus._valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " sum"}, bus._0, exp_sum);
        check({tag, " count"}, bus._1, exp_cnt);
        check({tag, " ready_busy"}, bus._ready, 0);
        check({tag, " child_starts"}, child_starts - starts0, (exp_lat == 1) ? 0 : 1);
        @(negedge clk);
        check({tag, " valid_pulse"}, bus._valid, 0);
        check({tag, " ready_after"}, bus._ready, 1);
        repeat (3) @(negedge clk);
        check({tag, " sum_hold"}, bus._0, exp_sum);
        check({tag, " count_hold"}, bus._1, exp_cnt);
    endtask

    initial begin
        int pulses;
        int starts0;
        logic signed [31:0] got_sum;
        logic signed [31:0] got_cnt;

        rst = 1'b1;
        bus._start = 1'b0;
        bus.base = '0;
        bus.limit = '0;
        bus.step = '0;
        repeat (2) @(negedge clk);
        check("reset ready", bus._ready, 1);
        check("reset valid", bus._valid, 0);
        check("reset sum", bus._0, 0);
        check("reset count", bus._1, 0);
        check("reset child_start", dut.child_start_q, 0);
        rst = 1'b0;

        run_op("evens", 0, 10, 2, 20, 5, 8);
        run_op("empty", 5, 5, 1, 0, 0, 1);
        run_op("zero_step", 0, 10, 0, 0, 0, 1);
        run_op("negative", -6, 0, 3, -9, 2, 5);
        run_op("wrap", 2147483640, 2147483647, 1, 2147483613, 7, 10);

        // Abort a long run mid-WAIT, then confirm nothing carries over.
        @(negedge clk);
        bus._start = 1'b1;
        bus.base = 0;
        bus.limit = 100;
        bus.step = 1;
        @(negedge clk);
        bus._start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", bus._ready, 1);
        check("abort valid", bus._valid, 0);
        check("abort sum", bus._0, 0);
        check("abort count", bus._1, 0);
        repeat (3) @(negedge clk);
        check("abort child_quiet", bus._valid, 0);
        run_op("after_abort", 0, 4, 1, 6, 4, 7);

        // Start coincident with reset must be ignored.
        @(negedge clk);
        starts0 = child_starts;
        rst = 1'b1;
        bus._start = 1'b1;
        bus.base = 0;
        bus.limit = 10;
        bus.step = 2;
        @(negedge clk);
        rst = 1'b0;
        bus._start = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus._valid) pulses++;
        end
        check("rst_start pulses", pulses, 0);
        check("rst_start child", child_starts - starts0, 0);
        check("rst_start ready", bus._ready, 1);

        // A second start while busy is dropped.
        @(negedge clk);
        bus._start = 1'b1;
        bus.base = 1;
        bus.limit = 4;
        bus.step = 1;
        @(negedge clk);
        bus._start = 1'b0;
        @(negedge clk);
        bus._start = 1'b1;
        bus.base = 0;
        bus.limit = 10;
        bus.step = 2;
        @(negedge clk);
        bus._start = 1'b0;
        pulses = 0;
        got_sum = '0;
        got_cnt = '0;
        repeat (30) begin
            if (bus._valid) begin
                if (pulses == 0) begin
                    got_sum = bus._0;
                    got_cnt = bus._1;
                end
                pulses++;
            end
            @(negedge clk);
        end
        check("busy pulses", pulses, 1);
        check("busy sum", got_sum, 6);
        check("busy count", got_cnt, 3);
        check("busy ready", bus._ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/range_reducer.md
RANGE_REDUCER -- requirements
Module: range_reducer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 _clock  input  1  system clock; all state updates on rising edge.
REQ-003 _reset  input  1  synchronous active-high reset.
REQ-004 _start  input  1  one-cycle request; base/limit/step sampled this cycle only.
REQ-005 base  input  32 signed  first value requested from the generator.
REQ-006 limit  input  32 signed  exclusive upper bound.
REQ-007 step  input  32 signed  increment.
REQ-008 _0  output  32 signed  reduced sum of all yielded values.
REQ-009 _1  output  32 signed  count of yielded values.
REQ-010 _ready  output  1  high when idle and able to accept _start.
REQ-011 _valid  output  1  high for exactly one cycle when _0/_1 hold the result.

Function
REQ-012 The block SHALL act as the caller (consumer) end of the generator protocol: it drives child _start and args, and consumes child _0/_valid/_ready.
REQ-013 States SHALL be IDLE, CALL, WAIT, DONE.
REQ-014 IDLE: _ready=1, _valid=0; on _start=1, latch args, clear sum/count, go to CALL, or go to DONE if step<=0 or base>=limit.
REQ-015 The degenerate case (step<=0 or base>=limit) SHALL never start the child and SHALL report sum=0, count=0.
REQ-016 CALL: drive child _start=1 with latched args for exactly one cycle; go to WAIT.
REQ-017 Child args SHALL be driven only in CALL; otherwise don't-care.
REQ-018 WAIT: every cycle child _valid=1, sum+=child _0 and count+=1, regardless of child _ready.
REQ-019 WAIT: when child _ready=1, go to DONE after accumulating any same-cycle valid value.
REQ-020 DONE: _valid=1, _ready=0, _0=sum, _1=count for one cycle; then go to IDLE.
REQ-021 _ready SHALL be 0 in CALL, WAIT and DONE; _start there SHALL be ignored.
REQ-022 Sum and count SHALL wrap modulo 2^32 (two's complement) with no saturation or overflow flag.
REQ-023 _0/_1 SHALL hold their last result in IDLE until the next accepted _start clears them.
REQ-024 Latency from _start to _valid SHALL be N+3 cycles for a child run of N cycles in WAIT, and 1 cycle for the degenerate case.

Reset
REQ-025 _reset SHALL force IDLE, _0=0, _1=0, _valid=0, _ready=1, and child _start=0.
REQ-026 The child SHALL share _reset; reset mid-operation SHALL abandon the run and accumulate nothing from it.
REQ-027 _start coincident with _reset SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/CALL/WAIT/DONE) and the data-width constant (32).
REQ-029 The block SHALL instantiate exactly one sub-module, the existing hrange generator, as child.
REQ-030 All reduction logic SHALL live in range_reducer, with no other sub-modules.

Verification
REQ-031 (0,10,2): values 0,2,4,6,8 -> _valid pulse with _0=20, _1=5, then _ready=1.
REQ-032 (5,5,1) and (0,10,0): no child _start -> _valid one cycle after _start, _0=0, _1=0.
REQ-033 (-6,0,3): values -6,-3 -> _0=-9, _1=2.
REQ-034 (2147483646,2147483647+... limit 2147483647, step 1) with base 2147483640: sum wraps -> _0 equals low 32 bits of the true sum, _1=7.
REQ-035 Pulse _reset during WAIT of (0,100,1), then start (0,4,1) -> _0=6, _1=4, with no carry-over from the aborted run.
REQ-036 Second _start asserted while busy -> ignored; exactly one _valid pulse with the first run's result.
